// File: rtl/alu_pipe_param_if.sv
// Operand/result handshake bundle for alu_pipe_param.
// master drives operands and consumes results; slave is the ALU itself.
interface alu_pipe_param_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_FUN;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_OUT;
    logic             Arith_flag;
    logic             Logic_flag;
    logic             CMP_flag;
    logic             Shift_flag;
    logic             Carry_flag;
    logic             Div0_flag;
    logic             busy;

    modport master (
        output in_valid, A, B, ALU_FUN, out_ready,
        input  in_ready, out_valid, ALU_OUT, Arith_flag, Logic_flag,
               CMP_flag, Shift_flag, Carry_flag, Div0_flag, busy
    );

    modport slave (
        input  in_valid, A, B, ALU_FUN, out_ready,
        output in_ready, out_valid, ALU_OUT, Arith_flag, Logic_flag,
               CMP_flag, Shift_flag, Carry_flag, Div0_flag, busy
    );
endinterface

// File: rtl/alu_pipe_param.sv
// Width-generic ALU with valid/ready input, a registered valid/ready result
// stage, carry/borrow/overflow and divide-by-zero reporting, and a
// sequential restoring divider (one quotient bit per cycle).
module alu_pipe_param #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic             clk,
    input logic             rst_n,
    alu_pipe_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;

    // Flag vector bit positions: {arith, logic, cmp, shift, carry, div0}
    localparam int F_ARITH = 5;
    localparam int F_LOGIC = 4;
    localparam int F_CMP   = 3;
    localparam int F_SHIFT = 2;
    localparam int F_CARRY = 1;
    localparam int F_DIV0  = 0;

    state_t             state;
    state_t             state_next;
    logic               in_ready;
    logic               accept;
    logic               start_div;

    logic [WIDTH:0]     sum_p0;
    logic [2*WIDTH-1:0] prod_p0;
    logic [WIDTH-1:0]   res_p0;
    logic [5:0]         flags_p0;

    logic [CNT_W-1:0]   cnt_p0;
    logic [WIDTH-1:0]   rem_p0;
    logic [WIDTH-1:0]   quo_p0;
    logic [WIDTH-1:0]   den_p0;

    logic [WIDTH-1:0]   res_p1;
    logic [5:0]         flags_p1;
    logic               vld_p1;

    // One restoring step: shift the next dividend bit into the remainder,
    // keep the trial difference when it does not underflow, and record the
    // outcome as the new quotient LSB. The shifted remainder needs WIDTH+1
    // bits, but the kept difference is always below the divisor.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] quo,
                                                    input logic [WIDTH-1:0] den);
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] trial;
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted[WIDTH-1:0] - den;
        if (shifted >= {1'b0, den}) begin
            return {trial, quo[WIDTH-2:0], 1'b1};
        end
        return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    endfunction

    // New work is taken only when idle and the result slot is free or draining,
    // so a divider result can never land on an unconsumed one.
    assign in_ready       = (state == IDLE) && (!vld_p1 || bus.out_ready);
    assign accept         = bus.in_valid && in_ready;
    assign start_div      = accept && (bus.ALU_FUN == OP_DIV) && (bus.B != '0);

    assign bus.in_ready   = in_ready;
    assign bus.busy       = (state == DIV);
    assign bus.out_valid  = vld_p1;
    assign bus.ALU_OUT    = res_p1;
    assign bus.Arith_flag = flags_p1[F_ARITH];
    assign bus.Logic_flag = flags_p1[F_LOGIC];
    assign bus.CMP_flag   = flags_p1[F_CMP];
    assign bus.Shift_flag = flags_p1[F_SHIFT];
    assign bus.Carry_flag = flags_p1[F_CARRY];
    assign bus.Div0_flag  = flags_p1[F_DIV0];

    // --- stage p0: single-cycle result and flags from the live operands ---
    always_comb begin
        sum_p0   = {1'b0, bus.A} + {1'b0, bus.B};
        prod_p0  = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        res_p0   = '0;
        flags_p0 = '0;
        case (bus.ALU_FUN)
            OP_ADD: begin
                res_p0            = sum_p0[WIDTH-1:0];
                flags_p0[F_ARITH] = 1'b1;
                flags_p0[F_CARRY] = sum_p0[WIDTH];
            end
            OP_SUB: begin
                res_p0            = bus.A - bus.B;
                flags_p0[F_ARITH] = 1'b1;
                flags_p0[F_CARRY] = (bus.A < bus.B);
            end
            OP_MUL: begin
                res_p0            = prod_p0[WIDTH-1:0];
                flags_p0[F_ARITH] = 1'b1;
                flags_p0[F_CARRY] = |prod_p0[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                // Only consumed when B is zero; nonzero B goes to the divider.
                res_p0            = '1;
                flags_p0[F_ARITH] = 1'b1;
                flags_p0[F_DIV0]  = 1'b1;
            end
            OP_AND:  begin res_p0 = bus.A & bus.B;    flags_p0[F_LOGIC] = 1'b1; end
            OP_OR:   begin res_p0 = bus.A | bus.B;    flags_p0[F_LOGIC] = 1'b1; end
            OP_NAND: begin res_p0 = ~(bus.A & bus.B); flags_p0[F_LOGIC] = 1'b1; end
            OP_NOR:  begin res_p0 = ~(bus.A | bus.B); flags_p0[F_LOGIC] = 1'b1; end
            OP_XOR:  begin res_p0 = bus.A ^ bus.B;    flags_p0[F_LOGIC] = 1'b1; end
            OP_XNOR: begin res_p0 = ~(bus.A ^ bus.B); flags_p0[F_LOGIC] = 1'b1; end
            OP_EQ: begin
                res_p0          = (bus.A == bus.B) ? WIDTH'(1) : '0;
                flags_p0[F_CMP] = 1'b1;
            end
            OP_GT: begin
                res_p0          = (bus.A > bus.B) ? WIDTH'(2) : '0;
                flags_p0[F_CMP] = 1'b1;
            end
            OP_LT: begin
                res_p0          = (bus.A < bus.B) ? WIDTH'(3) : '0;
                flags_p0[F_CMP] = 1'b1;
            end
            OP_SHR: begin res_p0 = bus.A >> 1; flags_p0[F_SHIFT] = 1'b1; end
            OP_SHL: begin res_p0 = bus.A << 1; flags_p0[F_SHIFT] = 1'b1; end
            default: begin
                // NOP opcode: zero result, no flags, still reported as valid.
                res_p0   = '0;
                flags_p0 = '0;
            end
        endcase
    end

    // Divider FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Divider FSM next state: iterate until the counter is exhausted, then
    // spend one cycle publishing the quotient.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_div) state_next = DIV;
            DIV:     if (cnt_p0 == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter: loaded with WIDTH on start, one decrement per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (start_div) begin
            cnt_p0 <= CNT_W'(WIDTH);
        end else if ((state == DIV) && (cnt_p0 != '0)) begin
            cnt_p0 <= cnt_p0 - CNT_W'(1);
        end
    end

    // Divider datapath: latch operands on start, then one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (start_div) begin
            rem_p0 <= '0;
            quo_p0 <= bus.A;
            den_p0 <= bus.B;
        end else if ((state == DIV) && (cnt_p0 != '0)) begin
            {rem_p0, quo_p0} <= div_step(rem_p0, quo_p0, den_p0);
        end
    end

    // --- stage p1: result register, held while downstream stalls ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            res_p1   <= '0;
            flags_p1 <= '0;
        end else if (state == DONE) begin
            vld_p1   <= 1'b1;
            res_p1   <= quo_p0;
            flags_p1 <= 6'b100000;
        end else if (accept && !start_div) begin
            vld_p1   <= 1'b1;
            res_p1   <= res_p0;
            flags_p1 <= flags_p0;
        end else if (bus.out_ready) begin
            vld_p1   <= 1'b0;
        end
    end
endmodule
